// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Purpose: groups the bus signals between the write-back requesters
// (ALU, load, multicycle unit) and the arbiter. It also groups the arbiter's
// register-file write port.
//
// Signals:
//   Req[2:0]        one write-back request per requester (0=ALU, 1=load, 2=mcu)
//   Addr0..Addr2    destination register of each requester (ADDR_W)
//   Data0..Data2    write data of each requester (DATA_W)
//   Gnt[2:0]        one-hot grant, combinational in the current cycle
//   Stall           more than one request is pending this cycle
//   WriteAddr       registered register-file write address
//   WriteData       registered register-file write data
//   RegWrite        registered register-file write enable
//   WrCount[7:0]    saturating count of committed (nonzero-address) writes
//
// Modports:
//   master - requester side (drives requests, sees grants and the write port)
//   slave  - arbiter side
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [2:0]        Req;
    logic [ADDR_W-1:0] Addr0;
    logic [ADDR_W-1:0] Addr1;
    logic [ADDR_W-1:0] Addr2;
    logic [DATA_W-1:0] Data0;
    logic [DATA_W-1:0] Data1;
    logic [DATA_W-1:0] Data2;
    logic [2:0]        Gnt;
    logic              Stall;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [7:0]        WrCount;

    modport master (
        output Req, Addr0, Addr1, Addr2, Data0, Data1, Data2,
        input  Gnt, Stall, WriteAddr, WriteData, RegWrite, WrCount
    );

    modport slave (
        input  Req, Addr0, Addr1, Addr2, Data0, Data1, Data2,
        output Gnt, Stall, WriteAddr, WriteData, RegWrite, WrCount
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose: round-robin arbiter between three write-back sources (ALU, load,
// multicycle unit) that share the single register-file write port. A request
// granted in cycle N is registered onto the write port and presented during
// cycle N+1. Writes to register $0 take a slot but never assert RegWrite.
//
// Ports:
//   Clock  - single clock, all state updates on its rising edge
//   Reset  - asynchronous, active-low reset
//   bus    - regfile_wb_arbiter_if.slave: requests in; grant, stall,
//            register-file write port and committed-write counter out
//
// Parameters:
//   DATA_W - write-data width (matches register-file data width)
//   ADDR_W - register-address width
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int N_REQ = 3;

    // Round-robin pointer: the requester index scanned first.
    logic [1:0]        ptrReg;
    logic [1:0]        ptrNext;
    logic [1:0]        scanBase;

    // Scan order: candIdx[k] is the requester examined at scan position k.
    logic [1:0]        candIdx [N_REQ];
    logic [N_REQ-1:0]  candReq;

    logic [1:0]        gntIdx;
    logic              gntValid;
    logic              grantOn;

    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    logic [ADDR_W-1:0] writeAddrReg;
    logic [ADDR_W-1:0] writeAddrNext;
    logic [DATA_W-1:0] writeDataReg;
    logic [DATA_W-1:0] writeDataNext;
    logic              regWriteReg;
    logic              regWriteNext;
    logic [7:0]        wrCountReg;
    logic [7:0]        wrCountNext;

    // An illegal pointer value of 3 scans as if it were 0; the next grant
    // rewrites the pointer with a legal value.
    assign scanBase = (ptrReg == 2'd3) ? 2'd0 : ptrReg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_scan
            localparam logic [2:0] OFFSET = 3'(gi);
            logic [2:0] sum;
            // (scanBase + gi) mod 3 without a divider: sum is at most 4.
            assign sum          = {1'b0, scanBase} + OFFSET;
            assign candIdx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign candReq[gi]  = bus.Req[candIdx[gi]];
        end
    endgenerate

    // Priority pick over the rotated order: iterating from the last scan
    // position down lets the earliest asserted position win.
    always_comb begin
        gntIdx   = 2'd0;
        gntValid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (candReq[i]) begin
                gntIdx   = candIdx[i];
                gntValid = 1'b1;
            end
        end
    end

    // No grant may be issued while reset is held.
    assign grantOn = gntValid & Reset;

    always_comb begin
        selAddr = bus.Addr0;
        selData = bus.Data0;
        case (gntIdx)
            2'd1: begin
                selAddr = bus.Addr1;
                selData = bus.Data1;
            end
            2'd2: begin
                selAddr = bus.Addr2;
                selData = bus.Data2;
            end
            default: ;
        endcase
    end

    always_comb begin
        ptrNext       = ptrReg;
        writeAddrNext = writeAddrReg;
        writeDataNext = writeDataReg;
        regWriteNext  = 1'b0;
        wrCountNext   = wrCountReg;
        if (grantOn) begin
            ptrNext       = (gntIdx == 2'd2) ? 2'd0 : gntIdx + 2'd1;
            writeAddrNext = selAddr;
            writeDataNext = selData;
            // A write to $0 still consumes the slot but is never committed.
            regWriteNext  = (selAddr != '0);
        end
        // Counted on the edge that loads RegWrite=1, so back-to-back writes
        // each count once.
        if (regWriteNext && (wrCountReg != 8'hFF)) begin
            wrCountNext = wrCountReg + 8'd1;
        end
    end

    // Asynchronous reset also discards any granted-but-uncommitted write.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ptrReg       <= 2'd0;
            writeAddrReg <= '0;
            writeDataReg <= '0;
            regWriteReg  <= 1'b0;
            wrCountReg   <= 8'd0;
        end else begin
            ptrReg       <= ptrNext;
            writeAddrReg <= writeAddrNext;
            writeDataReg <= writeDataNext;
            regWriteReg  <= regWriteNext;
            wrCountReg   <= wrCountNext;
        end
    end

    assign bus.Gnt       = grantOn ? (3'b001 << gntIdx) : 3'b000;
    // A single grant per cycle means a stall exactly when two or more
    // requests are pending.
    assign bus.Stall     = Reset & ((bus.Req[0] & bus.Req[1]) |
                                    (bus.Req[0] & bus.Req[2]) |
                                    (bus.Req[1] & bus.Req[2]));
    assign bus.WriteAddr = writeAddrReg;
    assign bus.WriteData = writeDataReg;
    assign bus.RegWrite  = regWriteReg;
    assign bus.WrCount   = wrCountReg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. A reference model predicts the
// grant, the registered write port and the committed-write count. Each
// expected write-port state is queued when the request is driven and popped
// after the following clock edge. A small register-file model follows the
// write port so that dropped writes can be observed.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [7:0]        cnt;
    } expT;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busIf ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busIf)
    );

    always #5 Clock = ~Clock;

    // Register file fed by the arbiter's write port.
    logic [DATA_W-1:0] tbRegs [32];
    always @(posedge Clock) begin
        if (busIf.RegWrite && (busIf.WriteAddr != '0)) begin
            tbRegs[busIf.WriteAddr] <= busIf.WriteData;
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    logic [1:0]        mPtr  = 2'd0;
    logic [ADDR_W-1:0] mAddr = '0;
    logic [DATA_W-1:0] mData = '0;
    logic              mRw   = 1'b0;
    logic [7:0]        mCnt  = 8'd0;
    expT               sbQ [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] modelGnt(input logic [2:0] req, input logic [1:0] ptr);
        int base;
        int idx;
        base = (ptr == 2'd3) ? 0 : int'(ptr);
        for (int k = 0; k < 3; k++) begin
            idx = (base + k) % 3;
            if (req[idx]) return 3'(1 << idx);
        end
        return 3'b000;
    endfunction

    // One arbitration cycle with the currently driven inputs.
    // Entered and left at posedge+1.
    task automatic tick();
        logic [2:0] eg;
        int         idx;
        expT        e;
        @(negedge Clock);
        eg = modelGnt(busIf.Req, mPtr);
        chk("gnt",   32'(busIf.Gnt),   32'(eg));
        chk("stall", 32'(busIf.Stall), 32'($countones(busIf.Req) > 1));
        if (eg != 3'b000) begin
            idx = eg[0] ? 0 : (eg[1] ? 1 : 2);
            case (idx)
                0: begin mAddr = busIf.Addr0; mData = busIf.Data0; end
                1: begin mAddr = busIf.Addr1; mData = busIf.Data1; end
                default: begin mAddr = busIf.Addr2; mData = busIf.Data2; end
            endcase
            mRw  = (mAddr != '0);
            mPtr = (idx == 2) ? 2'd0 : 2'(idx + 1);
            if (mRw && mCnt != 8'd255) mCnt = mCnt + 8'd1;
        end else begin
            mRw = 1'b0;
        end
        sbQ.push_back('{rw: mRw, addr: mAddr, data: mData, cnt: mCnt});
        @(posedge Clock);
        #1;
        e = sbQ.pop_front();
        chk("regWrite",  32'(busIf.RegWrite),  32'(e.rw));
        chk("writeAddr", 32'(busIf.WriteAddr), 32'(e.addr));
        chk("writeData", busIf.WriteData,      e.data);
        chk("wrCount",   32'(busIf.WrCount),   32'(e.cnt));
    endtask

    // Asserts reset (asynchronously, mid-cycle) with the given requests held.
    // Entered and left at posedge+1.
    task automatic resetPulse(input logic [2:0] req);
        Reset     = 1'b0;
        busIf.Req = req;
        #1;
        chk("rst regWrite",  32'(busIf.RegWrite),  32'd0);
        chk("rst writeAddr", 32'(busIf.WriteAddr), 32'd0);
        chk("rst writeData", busIf.WriteData,      32'd0);
        chk("rst wrCount",   32'(busIf.WrCount),   32'd0);
        @(negedge Clock);
        chk("rst gnt",   32'(busIf.Gnt),   32'd0);
        chk("rst stall", 32'(busIf.Stall), 32'd0);
        @(posedge Clock);
        #1;
        chk("rst hold regWrite", 32'(busIf.RegWrite), 32'd0);
        chk("rst hold wrCount",  32'(busIf.WrCount),  32'd0);
        sbQ.delete();
        mPtr  = 2'd0;
        mAddr = '0;
        mData = '0;
        mRw   = 1'b0;
        mCnt  = 8'd0;
        Reset = 1'b1;
    endtask

    task automatic drive(input logic [2:0] req,
                         input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
        busIf.Req   = req;
        busIf.Addr0 = a0;
        busIf.Data0 = d0;
        busIf.Addr1 = a1;
        busIf.Data1 = d1;
        busIf.Addr2 = a2;
        busIf.Data2 = d2;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) tbRegs[r] = '0;
        drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;

        // Reset with every requester active, then six cycles of full contention.
        resetPulse(3'b111);
        drive(3'b111, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, 5'd3, 32'h3333_0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            busIf.Data0 = busIf.Data0 + 32'd1;
            busIf.Data1 = busIf.Data1 + 32'd1;
            busIf.Data2 = busIf.Data2 + 32'd1;
        end
        chk("contention wrCount", 32'(busIf.WrCount), 32'd6);
        drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();

        // Single load write-back.
        resetPulse(3'b000);
        drive(3'b010, 5'd0, 32'h0, 5'd1, 32'hA5A5_A5A5, 5'd0, 32'h0);
        tick();
        chk("load wrCount", 32'(busIf.WrCount), 32'd1);
        drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();

        // Write to $0 consumes the slot and advances the pointer to 1.
        drive(3'b001, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        chk("zero wrCount", 32'(busIf.WrCount), 32'd1);
        drive(3'b111, 5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 32'h6);
        tick();

        // Mixed random traffic, including occasional $0 destinations.
        for (int i = 0; i < 24; i++) begin
            drive(3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), $urandom());
            tick();
        end

        // Saturation of the committed-write counter.
        resetPulse(3'b000);
        for (int i = 0; i < 260; i++) begin
            drive(3'b001, 5'd7, 32'(i), 5'd0, 32'h0, 5'd0, 32'h0);
            tick();
        end
        chk("sat wrCount", 32'(busIf.WrCount), 32'd255);
        drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();

        // Reset during the write cycle drops the pending write.
        resetPulse(3'b000);
        drive(3'b001, 5'd5, 32'h1111_1111, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        chk("reg5 first", tbRegs[5], 32'h1111_1111);
        drive(3'b001, 5'd5, 32'h2222_2222, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        resetPulse(3'b000);
        tick();
        tick();
        chk("reg5 kept", tbRegs[5], 32'h1111_1111);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the write-data width, which matches the register file data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register-address width, giving 32 registers with $0 hard-wired to zero.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, named Clock and Reset.
REQ-004 Port Clock  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port Reset  input  1  is the asynchronous, active-low reset.
REQ-006 Port Req  input  3  carries one write-back request per requester: 0=ALU, 1=load, 2=multicycle unit.
REQ-007 Ports Addr0/Addr1/Addr2  input  ADDR_W  are the destination registers of requesters 0/1/2.
REQ-008 Ports Data0/Data1/Data2  input  DATA_W  are the write data of requesters 0/1/2.
REQ-009 Port Gnt  output  3  is the one-hot grant; it is combinational in the current cycle.
REQ-010 Port WriteAddr  output  ADDR_W  is the registered address driven to the register file write port.
REQ-011 Port WriteData  output  DATA_W  is the registered data driven to the register file write port.
REQ-012 Port RegWrite  output  1  is the registered write enable driven to the register file.
REQ-013 Port Stall  output  1  is combinational: at least one asserted Req is not granted this cycle.
REQ-014 Port WrCount  output  8  is a saturating count of committed (nonzero-address) writes.

Function
REQ-015 Gnt SHALL be zero when Req==0, and otherwise one-hot, selecting the first asserted Req scanning Ptr, Ptr+1, Ptr+2 (mod 3).
REQ-016 Ptr SHALL be a 2-bit round-robin pointer with legal values 0..2; on a grant to index i it SHALL become (i+1) mod 3, and it SHALL hold when there is no grant.
REQ-017 On each edge with a grant to i, WriteAddr<=Addr_i and WriteData<=Data_i.
REQ-018 On each edge with a grant to i, RegWrite<=1 if Addr_i!=0, else RegWrite<=0.
REQ-019 On an edge without a grant, RegWrite SHALL be cleared to 0, and WriteAddr/WriteData SHALL hold.
REQ-020 Latency: a request granted in cycle N SHALL present RegWrite=1 during cycle N+1, and the register file SHALL commit at the edge ending cycle N+1.
REQ-021 Handshake: the requester SHALL hold Req/Addr/Data stable until it samples Gnt=1 at a rising edge, and SHALL deassert Req or present a new request in the following cycle.
REQ-022 A granted request to $0 SHALL consume the slot, update Ptr, drive RegWrite=0 and leave WrCount unchanged.
REQ-023 Fairness: a continuously held Req SHALL be granted within 3 cycles.
REQ-024 Stall SHALL equal (popcount(Req) > 1).
REQ-025 WrCount SHALL increment on each edge where the registered RegWrite becomes 1, and SHALL saturate at 255 without wrapping.
REQ-026 If Ptr ever holds 3, it SHALL be treated as 0 for the scan and then corrected on the next grant.

Reset
REQ-027 While Reset=0, the block SHALL force asynchronously Ptr=0, WriteAddr=0, WriteData=0, RegWrite=0, WrCount=0.
REQ-028 While Reset=0, Gnt=0 and Stall=0 regardless of Req.
REQ-029 Reset asserted mid-operation SHALL drop any granted-but-uncommitted write, so no RegWrite pulse follows deassertion.
REQ-030 After Reset deasserts, the first arbitration SHALL start from Ptr=0.

Verification
REQ-031 Reset pulse low with Req=3'b111 -> Gnt=0, RegWrite=0, WrCount=0; after release, first Gnt=3'b001.
REQ-032 Req=3'b010, Addr1=1, Data1=A5A5A5A5 -> Gnt=3'b010 in cycle N; cycle N+1 shows RegWrite=1, WriteAddr=1, WriteData=A5A5A5A5; WrCount=1.
REQ-033 Req held 3'b111 for 6 cycles, all Addr nonzero -> Gnt sequence 001,010,100,001,010,100; Stall=1 throughout; WrCount=6.
REQ-034 Req=3'b001, Addr0=0, Data0=DEADBEEF -> Gnt=3'b001, next cycle RegWrite=0, WrCount unchanged, Ptr=1.
REQ-035 260 back-to-back single-requester writes to register 7 -> WrCount=255 (saturated); RegWrite high every cycle after the first.
REQ-036 Reset asserted the cycle after a grant -> no RegWrite pulse; WriteAddr/WriteData=0; after release, regfile register unchanged.
